// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: NOP encoding, opcode types,
// controller state encoding and active levels.
package pipe_ctrl_pkg;

    localparam logic [31:0] INST_NOP        = 32'h0000_0013;

    localparam logic [6:0]  OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0]  OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0]  OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0]  OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0]  OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0]  OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0]  OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0]  OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0]  OPCODE_OP       = 7'b0110011;

    localparam logic        RST_ENABLE      = 1'b0;
    localparam logic        WRITE_ENABLE    = 1'b1;
    localparam int unsigned REG_ADDR_W      = 5;

    typedef enum logic [0:0] {
        StRun,
        StExWait
    } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never tracked.
// Lookups observe same-cycle clears; a same-cycle set wins over a clear.
module pipe_ctrl_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_NUM = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_addr,
    input  logic                  i_wb_clr_en,
    input  logic [REG_ADDR_W-1:0] i_wb_clr_addr,
    input  logic                  i_fl_clr_en,
    input  logic [REG_ADDR_W-1:0] i_fl_clr_addr,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    output logic                  o_rs1_pend,
    output logic                  o_rs2_pend,
    output logic                  o_rd_pend
);

    localparam logic [REG_NUM-1:0] X0_MASK = {{(REG_NUM-1){1'b1}}, 1'b0};

    logic [REG_NUM-1:0] r_pend;
    logic [REG_NUM-1:0] w_clr_mask;
    logic [REG_NUM-1:0] w_set_mask;
    logic [REG_NUM-1:0] w_pend_rd;
    logic [REG_NUM-1:0] w_pend_next;

    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (i_wb_clr_en) w_clr_mask[i_wb_clr_addr] = 1'b1;
        if (i_fl_clr_en) w_clr_mask[i_fl_clr_addr] = 1'b1;
        if (i_set_en)    w_set_mask[i_set_addr]    = 1'b1;
    end

    // Regfile writes through, so a writeback releases a dependent in the same cycle.
    assign w_pend_rd   = r_pend & ~w_clr_mask;
    assign w_pend_next = (w_pend_rd | w_set_mask) & X0_MASK;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign o_rs1_pend = (i_rs1_addr != '0) && w_pend_rd[i_rs1_addr];
    assign o_rs2_pend = (i_rs2_addr != '0) && w_pend_rd[i_rs2_addr];
    assign o_rd_pend  = (i_rd_addr  != '0) && w_pend_rd[i_rd_addr];

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: RAW/WAW stalls, EX redirects, and the EX multi-cycle
// hold with a sticky watchdog error.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_NUM      = 32,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned HOLD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1_addr_i,
    input  logic [4:0]        id_rs2_addr_i,
    input  logic [4:0]        id_rd_addr_i,
    input  logic              id_reg_wen_i,
    input  logic              ex_busy_i,
    input  logic              ex_jump_en_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              wb_reg_wen_i,
    input  logic [4:0]        wb_rd_addr_i,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              hold_id_ex_o,
    output logic              jump_en_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              err_o
);

    localparam int unsigned      CNT_W    = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_TIMEOUT);

    pipe_state_e      r_state, w_state_next;
    logic [CNT_W-1:0] r_hold_cnt, w_cnt_next;
    logic [4:0]       r_ex_rd, w_ex_rd_next;
    logic             r_ex_wen, w_ex_wen_next;
    logic             r_err, w_err_next;

    logic w_rs1_pend, w_rs2_pend, w_rd_pend, w_raw;
    logic w_set_en, w_fl_clr_en, w_rd_writes;
    logic w_hold_pc, w_hold_if_id, w_hold_id_ex, w_flush_if_id, w_flush_id_ex, w_jump_en;
    logic w_active;

    assign w_rd_writes = (id_reg_wen_i == WRITE_ENABLE) && (id_rd_addr_i != '0);

    pipe_ctrl_scoreboard #(
        .REG_NUM (REG_NUM)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_set_en      (w_set_en),
        .i_set_addr    (id_rd_addr_i),
        .i_wb_clr_en   (wb_reg_wen_i),
        .i_wb_clr_addr (wb_rd_addr_i),
        .i_fl_clr_en   (w_fl_clr_en),
        .i_fl_clr_addr (r_ex_rd),
        .i_rs1_addr    (id_rs1_addr_i),
        .i_rs2_addr    (id_rs2_addr_i),
        .i_rd_addr     (id_rd_addr_i),
        .o_rs1_pend    (w_rs1_pend),
        .o_rs2_pend    (w_rs2_pend),
        .o_rd_pend     (w_rd_pend)
    );

    assign w_raw = w_rs1_pend | w_rs2_pend | (id_reg_wen_i & w_rd_pend);

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_hold_cnt;
        w_ex_rd_next  = r_ex_rd;
        w_ex_wen_next = r_ex_wen;
        w_set_en      = 1'b0;
        w_fl_clr_en   = 1'b0;
        w_hold_pc     = 1'b0;
        w_hold_if_id  = 1'b0;
        w_hold_id_ex  = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_jump_en     = 1'b0;

        if (r_state == StExWait && ex_busy_i) begin
            // Jumps are ignored while the multi-cycle op is still running.
            w_hold_pc    = 1'b1;
            w_hold_if_id = 1'b1;
            w_hold_id_ex = 1'b1;
            if (r_hold_cnt < HOLD_MAX) w_cnt_next = r_hold_cnt + CNT_W'(1);
        end else begin
            w_state_next = StRun;
            w_cnt_next   = '0;
            if (ex_jump_en_i) begin
                w_jump_en     = 1'b1;
                w_flush_if_id = 1'b1;
                w_flush_id_ex = 1'b1;
                // The squashed id_ex instruction will never write back.
                w_fl_clr_en   = r_ex_wen;
                w_ex_wen_next = 1'b0;
            end else if (ex_busy_i) begin
                w_hold_pc    = 1'b1;
                w_hold_if_id = 1'b1;
                w_hold_id_ex = 1'b1;
                w_state_next = StExWait;
                w_cnt_next   = CNT_W'(1);
            end else if (w_raw) begin
                w_hold_pc     = 1'b1;
                w_hold_if_id  = 1'b1;
                w_flush_id_ex = 1'b1;
                w_ex_wen_next = 1'b0;
            end else begin
                w_set_en      = w_rd_writes;
                w_ex_rd_next  = id_rd_addr_i;
                w_ex_wen_next = w_rd_writes;
            end
        end

        w_err_next = r_err | (w_cnt_next == HOLD_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state    <= StRun;
            r_hold_cnt <= '0;
            r_ex_rd    <= '0;
            r_ex_wen   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_cnt_next;
            r_ex_rd    <= w_ex_rd_next;
            r_ex_wen   <= w_ex_wen_next;
            r_err      <= w_err_next;
        end
    end

    // Inputs may toggle during reset; keep every control output quiet until release.
    assign w_active      = (rst != RST_ENABLE);
    assign hold_pc_o     = w_active & w_hold_pc;
    assign hold_if_id_o  = w_active & w_hold_if_id;
    assign hold_id_ex_o  = w_active & w_hold_id_ex;
    assign flush_if_id_o = w_active & w_flush_if_id;
    assign flush_id_ex_o = w_active & w_flush_id_ex;
    assign jump_en_o     = w_active & w_jump_en;
    assign jump_addr_o   = (w_active & w_jump_en) ? ex_jump_addr_i : '0;
    assign err_o         = r_err;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: hazards, redirects, EX hold, watchdog, reset.
module tb_pipe_ctrl;

    localparam int unsigned ADDR_W = 32;

    // {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_en}
    localparam logic [5:0] C_IDLE  = 6'b000_000;
    localparam logic [5:0] C_STALL = 6'b110_010;
    localparam logic [5:0] C_HOLD  = 6'b111_000;
    localparam logic [5:0] C_JUMP  = 6'b000_111;

    logic              clk;
    logic              rst;
    logic [4:0]        id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic              id_reg_wen_i;
    logic              ex_busy_i, ex_jump_en_i;
    logic [ADDR_W-1:0] ex_jump_addr_i;
    logic              wb_reg_wen_i;
    logic [4:0]        wb_rd_addr_i;
    logic              hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o, hold_id_ex_o;
    logic              jump_en_o, err_o;
    logic [ADDR_W-1:0] jump_addr_o;

    int n_checks = 0;
    int n_errors = 0;

    pipe_ctrl #(
        .REG_NUM      (32),
        .ADDR_W       (ADDR_W),
        .HOLD_TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_rd_addr_i   (id_rd_addr_i),
        .id_reg_wen_i   (id_reg_wen_i),
        .ex_busy_i      (ex_busy_i),
        .ex_jump_en_i   (ex_jump_en_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .wb_reg_wen_i   (wb_reg_wen_i),
        .wb_rd_addr_i   (wb_rd_addr_i),
        .hold_pc_o      (hold_pc_o),
        .hold_if_id_o   (hold_if_id_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .hold_id_ex_o   (hold_id_ex_o),
        .jump_en_o      (jump_en_o),
        .jump_addr_o    (jump_addr_o),
        .err_o          (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [5:0] exp);
        check(tag, {26'd0, hold_pc_o, hold_if_id_o, hold_id_ex_o,
                    flush_if_id_o, flush_id_ex_o, jump_en_o}, {26'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wen);
        id_rs1_addr_i = rs1;
        id_rs2_addr_i = rs2;
        id_rd_addr_i  = rd;
        id_reg_wen_i  = wen;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd);
        wb_reg_wen_i = en;
        wb_rd_addr_i = rd;
    endtask

    task automatic set_ex(input logic busy, input logic jmp, input logic [31:0] addr);
        ex_busy_i      = busy;
        ex_jump_en_i   = jmp;
        ex_jump_addr_i = addr;
    endtask

    initial begin
        // Reset with noisy EX inputs: every output must stay low.
        rst = 1'b0;
        set_id(5'd1, 5'd2, 5'd3, 1'b1);
        set_wb(1'b0, 5'd0);
        set_ex(1'b1, 1'b1, 32'h55);
        #12;
        check_ctl("reset_ctl", C_IDLE);
        check("reset_jaddr", jump_addr_o, 32'h0);
        check("reset_err", {31'd0, err_o}, 32'd0);
        set_id(5'd0, 5'd0, 5'd0, 1'b0);
        set_ex(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();

        // addi x1,x0,5 then add x2,x1,x1
        set_id(5'd0, 5'd0, 5'd1, 1'b1);
        #1 check_ctl("addi_x1_issue", C_IDLE);
        tick();
        set_id(5'd1, 5'd1, 5'd2, 1'b1);
        #1 check_ctl("raw_stall_1", C_STALL);
        tick();
        check_ctl("raw_stall_2", C_STALL);
        tick();
        set_wb(1'b1, 5'd1);
        #1 check_ctl("raw_release_wb", C_IDLE);
        tick();
        set_wb(1'b0, 5'd0);
        set_id(5'd1, 5'd0, 5'd4, 1'b0);
        #1 check_ctl("x1_cleared", C_IDLE);
        tick();

        // addi x3 issued, then taken branch in EX while id would stall on x2
        set_id(5'd0, 5'd0, 5'd3, 1'b1);
        #1 check_ctl("addi_x3_issue", C_IDLE);
        tick();
        set_id(5'd2, 5'd0, 5'd5, 1'b1);
        set_ex(1'b0, 1'b1, 32'h40);
        #1 check_ctl("jump_ctl", C_JUMP);
        check("jump_addr", jump_addr_o, 32'h40);
        tick();
        set_ex(1'b0, 1'b0, 32'h0);
        set_id(5'd3, 5'd5, 5'd6, 1'b0);
        #1 check_ctl("x3_flushed", C_IDLE);
        tick();

        // x0 writes and reads never stall
        set_id(5'd0, 5'd0, 5'd0, 1'b1);
        #1 check_ctl("x0_write_1", C_IDLE);
        tick();
        check_ctl("x0_write_2", C_IDLE);
        tick();

        // WAW on x2 (still pending from add); wb clear + issue set in one cycle keeps bit
        set_id(5'd0, 5'd0, 5'd2, 1'b1);
        #1 check_ctl("waw_stall", C_STALL);
        tick();
        set_wb(1'b1, 5'd2);
        #1 check_ctl("waw_release", C_IDLE);
        tick();
        set_wb(1'b0, 5'd0);
        set_id(5'd2, 5'd0, 5'd0, 1'b0);
        #1 check_ctl("set_wins_over_clr", C_STALL);
        tick();
        set_wb(1'b1, 5'd2);
        #1 check_ctl("x2_release", C_IDLE);
        tick();
        set_wb(1'b0, 5'd0);

        // EX busy for 5 cycles; a jump during the hold is ignored, id writer not recorded
        set_id(5'd0, 5'd0, 5'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            set_ex(1'b1, (i == 2), 32'h99);
            #1 check_ctl($sformatf("busy_hold_%0d", i), C_HOLD);
            tick();
        end
        set_id(5'd0, 5'd0, 5'd0, 1'b0);
        set_ex(1'b0, 1'b1, 32'h80);
        #1 check_ctl("busy_exit_jump", C_JUMP);
        check("busy_exit_jaddr", jump_addr_o, 32'h80);
        check("busy_short_err", {31'd0, err_o}, 32'd0);
        tick();
        set_ex(1'b0, 1'b0, 32'h0);
        set_id(5'd7, 5'd0, 5'd0, 1'b0);
        #1 check_ctl("no_set_in_wait", C_IDLE);
        tick();

        // Watchdog: 63 busy cycles is fine, the 64th raises err
        set_id(5'd0, 5'd0, 5'd0, 1'b0);
        set_ex(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 63; i++) tick();
        check("err_before_timeout", {31'd0, err_o}, 32'd0);
        check_ctl("hold_at_63", C_HOLD);
        tick();
        check("err_at_timeout", {31'd0, err_o}, 32'd1);
        set_ex(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("err_sticky", {31'd0, err_o}, 32'd1);
        check_ctl("run_after_timeout", C_IDLE);

        // Reset during EX_WAIT with x5 pending
        set_id(5'd0, 5'd0, 5'd5, 1'b1);
        #1 check_ctl("addi_x5_issue", C_IDLE);
        tick();
        set_id(5'd5, 5'd0, 5'd0, 1'b0);
        set_ex(1'b1, 1'b0, 32'h0);
        tick();
        set_ex(1'b1, 1'b1, 32'h44);
        #1 check_ctl("pre_reset_hold", C_HOLD);
        rst = 1'b0;
        #1 check_ctl("mid_reset_ctl", C_IDLE);
        check("mid_reset_err", {31'd0, err_o}, 32'd0);
        check("mid_reset_jaddr", jump_addr_o, 32'h0);
        set_ex(1'b0, 1'b0, 32'h0);
        #1 rst = 1'b1;
        #1 check_ctl("post_reset_x5_clear", C_IDLE);
        tick();
        set_ex(1'b1, 1'b1, 32'h48);
        #1 check_ctl("post_reset_run_jump", C_JUMP);
        set_ex(1'b1, 1'b0, 32'h0);
        #1 check_ctl("post_reset_busy", C_HOLD);
        tick();
        check("post_reset_err", {31'd0, err_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
